// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, D = A - B, LSB first through one
// full-subtractor cell with a registered borrow; start/busy/done handshake.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last result
//   SHIFT | one difference bit per cycle, WIDTH cycles
//   DONE  | one-cycle done pulse; a start here is accepted directly
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V,
    output logic             Z
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             br_nxt;
    logic             sa;
    logic             sb;
    logic             dbit;
    logic             last;
    logic             accept;

    assign dbit    = ra[0] ^ rb[0] ^ br;
    assign br_nxt  = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
    assign res_nxt = {dbit, res[WIDTH-1:1]};
    assign last    = (cnt == CW'(WIDTH - 1));
    assign accept  = start && (state == IDLE || state == DONE);

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            D     <= '0;
            Bout  <= 1'b0;
            V     <= 1'b0;
            Z     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ra  <= A;
                rb  <= B;
                sa  <= A[WIDTH-1];
                sb  <= B[WIDTH-1];
                res <= '0;
                cnt <= '0;
                br  <= 1'b0;
            end else if (state == SHIFT) begin
                ra  <= {1'b0, ra[WIDTH-1:1]};
                rb  <= {1'b0, rb[WIDTH-1:1]};
                res <= res_nxt;
                br  <= br_nxt;
                cnt <= cnt + CW'(1);
                // Result registers load on the final bit so they are valid
                // in the DONE cycle and hold through the next operation.
                if (last) begin
                    D    <= res_nxt;
                    Bout <= br_nxt;
                    V    <= (sa != sb) && (dbit != sa);
                    Z    <= (res_nxt == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: arithmetic reference model checked
// every cycle, plus literal expectations for the listed operand pairs.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, Bout, V, Z;
    logic [W-1:0] D;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (A),
        .B    (B),
        .busy (busy),
        .done (done),
        .D    (D),
        .Bout (Bout),
        .V    (V),
        .Z    (Z)
    );

    always #5 clk = ~clk;

    // Reference model: cycle timing from the handshake rules, result from
    // plain integer arithmetic.
    logic         m_valid = 1'b0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_D = '0;
    logic         m_Bout = 1'b0, m_V = 1'b0, m_Z = 1'b0;
    logic [W-1:0] p_D;
    logic         p_Bout, p_V, p_Z;
    int           m_left = 0;

    task automatic compute(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] d, output logic bo,
                           output logic v, output logic z);
        int ua, ub, sa, sb, sdiff;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 2**(W-1)) ? ua - 2**W : ua;
        sb = (ub >= 2**(W-1)) ? ub - 2**W : ub;
        sdiff = sa - sb;
        d  = W'((ua - ub + 2**W) % 2**W);
        bo = (ua < ub);
        v  = (sdiff > 2**(W-1) - 1) || (sdiff < -(2**(W-1)));
        z  = (d == '0);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_D     = '0;
            m_Bout  = 1'b0;
            m_V     = 1'b0;
            m_Z     = 1'b0;
            m_left  = 0;
        end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_D    = p_D;
                m_Bout = p_Bout;
                m_V    = p_V;
                m_Z    = p_Z;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_busy = 1'b1;
                m_left = W;
                compute(A, B, p_D, p_Bout, p_V, p_Z);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if ({busy, done, D, Bout, V, Z} !== {m_busy, m_done, m_D, m_Bout, m_V, m_Z}) begin
                errors++;
                $display("FAIL model t=%0t busy/done/D/Bout/V/Z got %b/%b/%h/%b/%b/%b need %b/%b/%h/%b/%b/%b",
                         $time, busy, done, D, Bout, V, Z,
                         m_busy, m_done, m_D, m_Bout, m_V, m_Z);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h need %h", name, got, exp);
        end
    endtask

    task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge of the done cycle; n counts cycles after accept.
    task automatic wait_done(input string name, output int n);
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s timeout got done=%b need 1", name, done);
        end
    endtask

    task automatic check_result(input string name, input logic [W-1:0] ed,
                                input logic eb, input logic ev, input logic ez);
        check({name, "_D"}, 32'(D), 32'(ed));
        check({name, "_Bout"}, 32'(Bout), 32'(eb));
        check({name, "_V"}, 32'(V), 32'(ev));
        check({name, "_Z"}, 32'(Z), 32'(ez));
    endtask

    initial begin
        int n;
        int busy_cnt;

        // 1: reset then 5 - 3
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check_result("rst", 8'h00, 0, 0, 0);
        rst = 1'b0;
        pulse_start(8'h05, 8'h03);
        busy_cnt = 0;
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            n++;
        end
        check("t1_latency", 32'(n), 9);
        check("t1_busy_cycles", 32'(busy_cnt), 8);
        check("t1_busy_in_done", 32'(busy), 0);
        check_result("t1", 8'h02, 0, 0, 0);

        // 2: negative result
        pulse_start(8'h03, 8'h05);
        wait_done("t2", n);
        check_result("t2", 8'hFE, 1, 0, 0);

        // 3: signed overflow both directions
        pulse_start(8'h80, 8'h01);
        wait_done("t3a", n);
        check_result("t3a", 8'h7F, 0, 1, 0);
        pulse_start(8'h7F, 8'hFF);
        wait_done("t3b", n);
        check_result("t3b", 8'h80, 1, 1, 0);

        // 4: zero result, then start held in DONE for back-to-back
        pulse_start(8'hA5, 8'hA5);
        wait_done("t4a", n);
        check_result("t4a", 8'h00, 0, 0, 1);
        A = 8'h10;
        B = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 8'h55;
        B = 8'h22;
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            if (D !== 8'h00 || Z !== 1'b1) begin
                check("t4_hold", 32'({D, Z}), 32'({8'h00, 1'b1}));
            end
            @(negedge clk);
            n++;
        end
        check("t4_b2b_latency", 32'(n), 9);
        check_result("t4b", 8'h0F, 0, 0, 0);

        // 5: start during SHIFT is ignored
        pulse_start(8'h10, 8'h01);
        @(negedge clk);
        @(negedge clk);
        A = 8'hFF;
        B = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5", n);
        check_result("t5", 8'h0F, 0, 0, 0);
        @(negedge clk);
        check("t5_no_second_op", 32'(busy), 0);

        // 6: reset mid-operation discards the result
        pulse_start(8'h10, 8'h01);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_busy", 32'(busy), 0);
        check("t6_done", 32'(done), 0);
        check_result("t6", 8'h00, 0, 0, 0);
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        check("t6_no_done", 32'(n), 0);
        pulse_start(8'h00, 8'h01);
        wait_done("t6b", n);
        check("t6b_latency", 32'(n), 9);
        check_result("t6b", 8'hFF, 1, 0, 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
